// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a SPR_H x SPR_W sprite from the sprite ROM mux into
// the frame buffer at a latched screen origin. Transparent-key pixels and
// off-screen pixels are skipped. Each pixel takes a FETCH cycle (address out
// to the ROM) and a WRITE cycle (ROM data back, frame-buffer write). Writes
// stall in WRITE until fb_ready is seen.
module sprite_blitter #(
    parameter int          SPR_H     = 24,
    parameter int          SPR_W     = 32,
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter logic [9:0]  KEY_COLOR = 10'd391,
    parameter bit          TRANSP_EN = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [9:0]  x_org,
    input  logic [8:0]  y_org,
    output logic [4:0]  spr_row,
    output logic [4:0]  spr_col,
    input  logic [9:0]  spr_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [9:0]  fb_data,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done,
    output logic [9:0]  wr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0]  ROW_LAST = 5'(SPR_H - 1);
    localparam logic [4:0]  COL_LAST = 5'(SPR_W - 1);
    // Screen limits widened so that origin + offset never wraps in the compare.
    localparam logic [10:0] X_LIMIT  = 11'(SCREEN_W);
    localparam logic [9:0]  Y_LIMIT  = 10'(SCREEN_H);

    // Linear frame-buffer index of an on-screen pixel (19-bit multiply-add).
    function automatic logic [18:0] fb_index(input logic [9:0] ys, input logic [10:0] xs);
        logic [18:0] prod;
        prod = 19'(ys) * 19'(SCREEN_W);
        return prod + 19'(xs);
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [9:0]  wr_count_q, wr_count_d;
    logic [18:0] fb_addr_q, fb_addr_d;

    logic [10:0] x_sum;
    logic [9:0]  y_sum;
    logic        on_screen;
    logic        is_key;
    logic        skip;
    logic        last_px;
    logic [18:0] pix_addr;

    // Pixel position, visibility and skip decision for the current row/col.
    always_comb begin
        x_sum     = {1'b0, x_q} + {6'd0, col_q};
        y_sum     = {1'b0, y_q} + {5'd0, row_q};
        on_screen = (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);
        is_key    = TRANSP_EN && (spr_data == KEY_COLOR);
        skip      = is_key || !on_screen;
        last_px   = (row_q == ROW_LAST) && (col_q == COL_LAST);
        pix_addr  = fb_index(y_sum, x_sum);
    end

    // Next-state logic: start handshake, pixel walk, write stall and advance.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_count_d = wr_count_q;
        fb_addr_d  = fb_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d        = x_org;
                    y_d        = y_org;
                    row_d      = 5'd0;
                    col_d      = 5'd0;
                    wr_count_d = 10'd0;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                // Address is loaded here so it is stable for the whole WRITE
                // cycle; off-screen positions keep the previous value so only
                // valid addresses ever appear on fb_addr.
                if (on_screen) begin
                    fb_addr_d = pix_addr;
                end
                state_d = S_WRITE;
            end

            S_WRITE: begin
                if (skip || fb_ready) begin
                    if (!skip) begin
                        wr_count_d = wr_count_q + 10'd1;
                    end
                    if (last_px) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        if (col_q == COL_LAST) begin
                            col_d = 5'd0;
                            row_d = row_q + 5'd1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any blit in progress.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            x_q        <= 10'd0;
            y_q        <= 9'd0;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            wr_count_q <= 10'd0;
            fb_addr_q  <= 19'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_count_q <= wr_count_d;
            fb_addr_q  <= fb_addr_d;
        end
    end

    // Outputs decoded from the registers; the ROM address is held through a
    // stall, so spr_data (and hence fb_data) stays stable while fb_we waits.
    always_comb begin
        spr_row  = row_q;
        spr_col  = col_q;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        fb_we    = (state_q == S_WRITE) && !skip;
        fb_addr  = fb_addr_q;
        fb_data  = fb_we ? spr_data : 10'd0;
        wr_count = wr_count_q;
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: directed table of blits, hand-written restart and
// abort sequences, and randomised sprites/origins/fb_ready against a
// row-major reference model of the visible, non-transparent pixels.
module tb_sprite_blitter;

    localparam int SW        = 640;
    localparam int SH        = 480;
    localparam int NPIX      = 24 * 32;
    localparam int KEY       = 391;
    localparam int BASE_DONE = 2 * NPIX + 1;
    localparam int BUDGET    = 4000;

    logic        Clk = 1'b0;
    logic        Reset_n, start, fb_ready, fb_ready_nt;
    logic [9:0]  x_org;
    logic [8:0]  y_org;
    logic [9:0]  spr_data, spr_data_nt;
    logic [4:0]  spr_row, spr_col, spr_row_nt, spr_col_nt;
    logic        fb_we, fb_we_nt, busy, busy_nt, done, done_nt;
    logic [18:0] fb_addr, fb_addr_nt;
    logic [9:0]  fb_data, fb_data_nt, wr_count, wr_count_nt;

    logic [9:0]  sprite [0:1023];

    always #5 Clk = ~Clk;

    // Synchronous sprite ROM: data valid the cycle after the address.
    always @(posedge Clk) begin
        spr_data    <= sprite[{spr_row, spr_col}];
        spr_data_nt <= sprite[{spr_row_nt, spr_col_nt}];
    end

    sprite_blitter dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .x_org(x_org), .y_org(y_org),
        .spr_row(spr_row), .spr_col(spr_col), .spr_data(spr_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .busy(busy), .done(done), .wr_count(wr_count)
    );

    sprite_blitter #(.TRANSP_EN(1'b0)) dut_nt (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .x_org(x_org), .y_org(y_org),
        .spr_row(spr_row_nt), .spr_col(spr_col_nt), .spr_data(spr_data_nt),
        .fb_we(fb_we_nt), .fb_addr(fb_addr_nt), .fb_data(fb_data_nt), .fb_ready(fb_ready_nt),
        .busy(busy_nt), .done(done_nt), .wr_count(wr_count_nt)
    );

    typedef struct {
        int x;
        int y;
        int fill;
        int stall;
        int exp_wr;
        int exp_first;
        int exp_last;
        int exp_done;
        bit chk_nt;
        int exp_nt_wr;
    } vec_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    string tag      = "reset";

    int m_addr[$], m_data[$], n_addr[$], n_data[$];
    int g_addr[$], g_data[$], h_addr[$], h_data[$];

    int done_cyc, done_nt_cyc, done_pulses, wrc_at_done, wrc_nt_at_done;
    int stalls, hold_err, max_addr, busy_after;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
    endtask

    task automatic fill_sprite(input int v);
        for (int i = 0; i < 1024; i++) sprite[i] = 10'(v);
    endtask

    // Reference: every sprite pixel in row-major order that lands on screen,
    // minus key-colour pixels when transparency is enabled.
    task automatic build_model(input int x, input int y);
        int col;
        m_addr.delete(); m_data.delete(); n_addr.delete(); n_data.delete();
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 32; c++) begin
                col = int'(sprite[r * 32 + c]);
                if (x + c < SW && y + r < SH) begin
                    n_addr.push_back((y + r) * SW + x + c);
                    n_data.push_back(col);
                    if (col != KEY) begin
                        m_addr.push_back((y + r) * SW + x + c);
                        m_data.push_back(col);
                    end
                end
            end
        end
    endtask

    task automatic run_blit(input int x, input int y, input int stall, input bit rnd,
                            input int repulse, input int abort_at);
        int          stall_left;
        int          e;
        int          last_e;
        bit          hold_pend;
        logic [18:0] h_a;
        logic [9:0]  h_d;
        build_model(x, y);
        g_addr.delete(); g_data.delete(); h_addr.delete(); h_data.delete();
        done_cyc = -1; done_nt_cyc = -1; done_pulses = 0; wrc_at_done = -1; wrc_nt_at_done = -1;
        stalls = 0; hold_err = 0; max_addr = 0; busy_after = -1;
        stall_left = stall; hold_pend = 1'b0; h_a = '0; h_d = '0;
        x_org = 10'(x); y_org = 9'(y); start = 1'b1; fb_ready = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        e = 0;
        last_e = BUDGET;
        while (e < last_e) begin
            if (hold_pend && !(fb_we && fb_addr == h_a && fb_data == h_d)) hold_err++;
            if (fb_we && stall_left > 0) begin
                fb_ready = 1'b0;
                stall_left--;
            end else if (rnd) fb_ready = ($urandom_range(0, 3) != 0);
            else fb_ready = 1'b1;
            hold_pend = 1'b0;
            if (fb_we) begin
                if (fb_ready) begin
                    g_addr.push_back(int'(fb_addr));
                    g_data.push_back(int'(fb_data));
                    if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
                end else begin
                    stalls++;
                    hold_pend = 1'b1;
                    h_a = fb_addr;
                    h_d = fb_data;
                end
            end
            if (fb_we_nt) begin
                h_addr.push_back(int'(fb_addr_nt));
                h_data.push_back(int'(fb_data_nt));
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc = e + 1;
                    wrc_at_done = int'(wr_count);
                end
            end
            if (done_nt && done_nt_cyc < 0) begin
                done_nt_cyc = e + 1;
                wrc_nt_at_done = int'(wr_count_nt);
            end
            if (done_cyc >= 0 && e == done_cyc) busy_after = int'(busy);
            if (done_cyc >= 0 && done_nt_cyc >= 0 && last_e == BUDGET) last_e = e + 2;
            if (e == repulse) begin
                x_org = 10'(x + 200);
                y_org = 9'(y + 100);
                start = 1'b1;
            end else if (e == repulse + 1) start = 1'b0;
            if (e == abort_at) begin
                #2 Reset_n = 1'b0;
                #1;
                check("abort_fb_we", int'(fb_we), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_done", int'(done), 0);
                check("abort_fb_addr", int'(fb_addr), 0);
                check("abort_wr_count", int'(wr_count), 0);
                break;
            end
            @(posedge Clk); #1;
            e++;
        end
        if (e == abort_at) begin
            repeat (2) @(posedge Clk);
            #1;
            check("abort_no_done", done_pulses + int'(done), 0);
            check("abort_held_idle", int'(busy), 0);
            @(negedge Clk) Reset_n = 1'b1;
            @(posedge Clk); #1;
        end
    endtask

    task automatic score(input int exp_wr, input int exp_first, input int exp_last,
                         input int exp_done, input bit chk_nt, input int exp_nt_wr);
        int err;
        check("n_writes", g_addr.size(), m_addr.size());
        err = 0;
        for (int i = 0; i < g_addr.size() && i < m_addr.size(); i++)
            if (g_addr[i] != m_addr[i] || g_data[i] != m_data[i]) err++;
        check("write_seq_err", err, 0);
        if (exp_wr >= 0) check("n_writes_tbl", g_addr.size(), exp_wr);
        if (exp_first >= 0) check("first_addr", (g_addr.size() > 0) ? g_addr[0] : -1, exp_first);
        if (exp_last >= 0) begin
            check("last_addr", (g_addr.size() > 0) ? g_addr[g_addr.size() - 1] : -1, exp_last);
            check("max_addr", max_addr, exp_last);
        end
        check("addr_in_range", int'(max_addr < SW * SH), 1);
        check("done_cycle", done_cyc, BASE_DONE + stalls);
        if (exp_done >= 0) check("done_cycle_tbl", done_cyc, exp_done);
        check("done_pulses", done_pulses, 1);
        check("busy_after_done", busy_after, 0);
        check("wr_count", wrc_at_done, m_addr.size());
        check("hold_stable", hold_err, 0);
        if (chk_nt) begin
            check("nt_n_writes", h_addr.size(), n_addr.size());
            err = 0;
            for (int i = 0; i < h_addr.size() && i < n_addr.size(); i++)
                if (h_addr[i] != n_addr[i] || h_data[i] != n_data[i]) err++;
            check("nt_write_seq_err", err, 0);
            check("nt_wr_count", wrc_nt_at_done, n_addr.size());
            check("nt_done_cycle", done_nt_cyc, BASE_DONE);
            if (exp_nt_wr >= 0) check("nt_n_writes_tbl", h_addr.size(), exp_nt_wr);
        end
    endtask

    vec_t tbl [4];

    initial begin
        Reset_n = 1'b1; start = 1'b0; fb_ready = 1'b1; fb_ready_nt = 1'b1;
        x_org = '0; y_org = '0;
        fill_sprite(0);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        check("rst_spr_row", int'(spr_row), 0);
        check("rst_spr_col", int'(spr_col), 0);
        check("rst_wr_count", int'(wr_count), 0);
        repeat (3) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk); #1;

        //          x    y    fill stall wr   first   last    done  nt  nt_wr
        tbl[0] = '{100,  50,  430, 0,    768, 32100,  46851,  1537, 1'b0, -1};
        tbl[1] = '{100,  50,  391, 0,    0,   -1,     -1,     1537, 1'b1, 768};
        tbl[2] = '{620,  470, 430, 0,    200, 301420, 307199, 1537, 1'b1, 200};
        tbl[3] = '{100,  50,  430, 5,    768, 32100,  46851,  1542, 1'b0, -1};
        for (int i = 0; i < 4; i++) begin
            tag = $sformatf("tbl%0d", i);
            fill_sprite(tbl[i].fill);
            run_blit(tbl[i].x, tbl[i].y, tbl[i].stall, 1'b0, -1, -1);
            score(tbl[i].exp_wr, tbl[i].exp_first, tbl[i].exp_last, tbl[i].exp_done,
                  tbl[i].chk_nt, tbl[i].exp_nt_wr);
        end

        tag = "restart_ignored";
        fill_sprite(430);
        run_blit(100, 50, 0, 1'b0, 100, -1);
        score(768, 32100, 46851, 1537, 1'b0, -1);

        tag = "abort";
        run_blit(100, 50, 0, 1'b0, -1, 400);
        tag = "after_abort";
        run_blit(100, 50, 0, 1'b0, -1, -1);
        score(768, 32100, 46851, 1537, 1'b1, 768);

        for (int k = 0; k < 5; k++) begin
            tag = $sformatf("rand%0d", k);
            for (int i = 0; i < 1024; i++)
                sprite[i] = ($urandom_range(0, 3) == 0) ? 10'(KEY) : 10'($urandom_range(0, 1023));
            if (k == 0) run_blit(639, 479, 0, 1'b1, -1, -1);
            else run_blit(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)), 0, 1'b1, -1, -1);
            score(-1, -1, -1, -1, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reader side of the sprite ROM interface: walks a 24-row x 32-column sprite (10-bit colour per pixel) and copies it into the 640x480 frame buffer at a latched screen origin.
- Sits between the sprite ROM mux (digit/tile sprites) and the frame-buffer write port, and is driven by the game renderer.
- Skips pixels that carry the transparent key colour and pixels that fall off-screen.
- Reports completion with a one-cycle done pulse.

Parameters:
- SPR_H, 24, sprite rows
- SPR_W, 32, sprite columns
- SCREEN_W, 640, frame-buffer width in pixels
- SCREEN_H, 480, frame-buffer height in pixels
- KEY_COLOR, 10'd391, transparent colour; pixels of this colour are not written
- TRANSP_EN, 1, 1 = skip KEY_COLOR pixels, 0 = write every pixel

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  request a blit; sampled only in IDLE
- x_org  in  10  screen x of sprite column 0; latched on accepted start
- y_org  in  9  screen y of sprite row 0; latched on accepted start
- spr_row  out  5  sprite row address to the ROM mux
- spr_col  out  5  sprite column address to the ROM mux
- spr_data  in  10  sprite pixel colour; valid 1 cycle after spr_row/spr_col
- fb_we  out  1  frame-buffer write request
- fb_addr  out  19  frame-buffer address, (y_org+row)*SCREEN_W + (x_org+col)
- fb_data  out  10  colour to write
- fb_ready  in  1  frame buffer accepts the write this cycle
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the blit completes
- wr_count  out  10  pixels actually written in the current/last blit

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; busy=0, done=0, fb_we=0.
  - fb_addr=0, fb_data=0, spr_row=0, spr_col=0, wr_count=0.
- States IDLE, FETCH, WRITE, DONE. All outputs are registered or decoded from state registers.
- IDLE:
  - On start=1: latch x_org/y_org, clear row/col/wr_count, go to FETCH.
  - start is ignored in every other state.
- FETCH: drive spr_row/spr_col = current row/col, then go to WRITE.
- WRITE: spr_data is valid.
  - Skip the pixel if TRANSP_EN && spr_data==KEY_COLOR, or x_org+col >= SCREEN_W, or y_org+row >= SCREEN_H.
  - Compare in 11-bit (x) and 10-bit (y) arithmetic so there is no wraparound.
  - If skipped, advance immediately.
  - Otherwise assert fb_we with fb_addr/fb_data. While fb_ready=0, hold fb_we, fb_addr and fb_data stable. Advance in the cycle fb_ready=1; wr_count increments on that cycle.
- Advance:
  - col+1; at col==SPR_W-1, col wraps to 0 and row+1.
  - After row SPR_H-1 / col SPR_W-1, go to DONE; otherwise go to FETCH.
- DONE: done=1 for exactly one cycle, busy still 1, then go to IDLE.
- Throughput: 2 cycles per pixel with fb_ready held high. A full blit takes 2*SPR_H*SPR_W cycles plus 1 DONE cycle, independent of how many pixels are skipped.
- fb_addr is computed with a 19-bit unsigned multiply-add from the latched origin. Only in-range addresses (< 307200) are ever emitted.
- fb_ready is ignored when fb_we=0.
- Reset asserted mid-blit aborts immediately: no done pulse, and all outputs return to reset values.

Test Plan:
- Sprite all 10'd430, origin (100,50), fb_ready=1, start sampled at edge 0 -> 768 writes; first fb_addr=32100, last fb_addr=46851; done high in cycle 1537; wr_count=768.
- Sprite all 10'd391, TRANSP_EN=1 -> fb_we never asserted; done still at cycle 1537; wr_count=0. With TRANSP_EN=0 -> 768 writes of data 391.
- Origin (620,470), sprite all 430 -> only cols 0..19 and rows 0..9 written: 200 writes; max fb_addr=479*640+639=307199.
- fb_ready held low 5 cycles on the first write -> fb_we/fb_addr=32100/fb_data held stable for 6 cycles; done shifts to cycle 1542.
- start pulsed again at cycle 100 with a different origin -> ignored; all addresses still use (100,50).
- Reset_n dropped at cycle 400 -> fb_we=0, busy=0 asynchronously; after release, a new start runs a complete blit with wr_count restarting from 0.
